// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared types and constants for the reaction-timer controller.
package rt_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, GO, HOLD} state_t;
  typedef enum logic [1:0] {ST_NONE, ST_OK, ST_CHEAT, ST_TIMEOUT} status_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam int TIME_W  = 14;
  localparam int DELAY_W = 17;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_ms_tick_gen.sv
// Millisecond tick prescaler; a synchronous clear restarts a full period.
module ms_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: random arm delay, GO LED, ms reaction timing and
// display-hold handshake before returning to idle.
module reaction_timer_ctrl
  import rt_pkg::*;
#(
  parameter int          TICK_DIV     = 100000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [15:0] RAND_MASK    = 16'h0FFF,
  parameter int          MAX_MS       = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              display_wait_done,
  output logic              display_wait,
  output logic              led_go,
  output logic [TIME_W-1:0] time_ms,
  output logic [1:0]        status,
  output logic              result_valid,
  output logic              busy
);

  state_t               r_state, w_state_next;
  status_t              r_status, w_status_next;
  logic [15:0]          r_lfsr;
  logic [DELAY_W-1:0]   r_delay_ms, w_delay_next;
  logic [DELAY_W-1:0]   r_ms_cnt, w_ms_next;
  logic [TIME_W-1:0]    r_time_ms, w_time_next;
  logic                 r_led_go, w_led_next;
  logic                 r_result_valid, w_rv_next;
  logic                 r_display_wait, r_busy, r_hold_first;
  logic                 w_tick, w_tick_clear;
  logic [DELAY_W-1:0]   w_ms_inc;
  logic [TIME_W-1:0]    w_time_inc;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .i_rst   (reset),
    .i_clear (w_tick_clear),
    .o_tick  (w_tick)
  );

  assign w_ms_inc   = r_ms_cnt + 1'b1;
  assign w_time_inc = r_time_ms + 1'b1;

  always_comb begin
    w_state_next  = r_state;
    w_status_next = r_status;
    w_delay_next  = r_delay_ms;
    w_ms_next     = r_ms_cnt;
    w_time_next   = r_time_ms;
    w_led_next    = r_led_go;
    w_rv_next     = 1'b0;
    w_tick_clear  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_delay_next  = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(r_lfsr & RAND_MASK);
          w_ms_next     = '0;
          w_status_next = ST_NONE;
          w_tick_clear  = 1'b1;
          w_state_next  = WAIT;
        end
      end
      WAIT: begin
        w_led_next = 1'b0;
        // Stop is checked first so an early press beats a coincident expiry.
        if (stop) begin
          w_status_next = ST_CHEAT;
          w_time_next   = '0;
          w_rv_next     = 1'b1;
          w_state_next  = HOLD;
        end else if (w_tick) begin
          w_ms_next = w_ms_inc;
          if (w_ms_inc == r_delay_ms) begin
            w_led_next   = 1'b1;
            w_time_next  = '0;
            w_tick_clear = 1'b1;
            w_state_next = GO;
          end
        end
      end
      GO: begin
        w_led_next = 1'b1;
        if (stop) begin
          w_led_next    = 1'b0;
          w_status_next = ST_OK;
          w_rv_next     = 1'b1;
          w_state_next  = HOLD;
        end else if (w_tick) begin
          if (w_time_inc >= TIME_W'(MAX_MS)) begin
            w_time_next   = TIME_W'(MAX_MS);
            w_led_next    = 1'b0;
            w_status_next = ST_TIMEOUT;
            w_rv_next     = 1'b1;
            w_state_next  = HOLD;
          end else begin
            w_time_next = w_time_inc;
          end
        end
      end
      HOLD: begin
        // The done flag may be left over from the previous hold on entry.
        if (!r_hold_first && display_wait_done) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_status       <= ST_NONE;
      r_lfsr         <= LFSR_SEED;
      r_delay_ms     <= '0;
      r_ms_cnt       <= '0;
      r_time_ms      <= '0;
      r_led_go       <= 1'b0;
      r_result_valid <= 1'b0;
      r_display_wait <= 1'b0;
      r_busy         <= 1'b0;
      r_hold_first   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_status       <= w_status_next;
      r_lfsr         <= lfsr_step(r_lfsr);
      r_delay_ms     <= w_delay_next;
      r_ms_cnt       <= w_ms_next;
      r_time_ms      <= w_time_next;
      r_led_go       <= w_led_next;
      r_result_valid <= w_rv_next;
      r_display_wait <= (w_state_next == HOLD);
      r_busy         <= (w_state_next != IDLE);
      r_hold_first   <= (r_state != HOLD) && (w_state_next == HOLD);
    end
  end

  assign display_wait = r_display_wait;
  assign led_go       = r_led_go;
  assign time_ms      = r_time_ms;
  assign status       = r_status;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;

endmodule
